branch_resolve_ctrl: RTL and testbench
======================================

Name: branch_resolve_ctrl

Overview:
- Sequences the ID-stage branch comparator in the 5-stage MIPS pipeline.
- Detects branch-operand hazards against in-flight EX and MEM instructions and stalls the front end for the required number of cycles.
- Selects comparator operand forwarding, then drives PCSrc and the IF/ID flush from the comparator's Taken result.
- Keeps saturating branch and taken counters for performance debug.

Parameters:
- CNT_W, 16, width of the BranchCount and TakenCount statistics counters.

Ports:
- Clk  input  1  pipeline clock.
- Reset  input  1  synchronous, active-high; sampled on rising Clk.
- BranchValid  input  1  ID holds a valid instruction.
- Opcode  input  6  ID instruction opcode.
- Rs  input  5  ID rs field.
- Rt  input  5  ID rt field.
- EX_RegWrite  input  1  EX instruction writes a register.
- EX_MemRead  input  1  EX instruction is a load.
- EX_Rd  input  5  EX destination register.
- MEM_RegWrite  input  1  MEM instruction writes a register.
- MEM_MemRead  input  1  MEM instruction is a load.
- MEM_Rd  input  5  MEM destination register.
- TakenIn  input  1  comparator result for the current operands.
- Stall  output  1  hold PC and IF/ID; insert bubble into ID/EX.
- ForwardA  output  2  comparator A source: 00 regfile, 01 EX/MEM result, 10 MEM/WB result.
- ForwardB  output  2  comparator B source, same encoding.
- PCSrc  output  1  select branch target.
- FlushIFID  output  1  squash the instruction in IF/ID.
- BranchCount  output  CNT_W  resolved branches, saturating.
- TakenCount  output  CNT_W  taken branches, saturating.

Behaviour:
- Clocking and reset: single clock domain; Reset is synchronous and active-high. On Reset the state goes to IDLE, StallCnt is 0, both counters are 0, and all outputs are 0. A Reset during STALL or RESOLVE abandons the branch with no PCSrc or flush.
- Branch decode: isBranch = BranchValid and Opcode in {000001, 000100, 000101, 000110, 000111}.
- Operands used: beq and bne use Rs and Rt. REGIMM, blez and bgtz use Rs only; Rt dependence is ignored for them.
- A dependency match requires a non-zero register number: register 0 never produces a hazard or a forward.
- Stall need: need = max over used operands of:
  - 2 if EX_RegWrite, EX_MemRead and EX_Rd matches;
  - 1 if EX_RegWrite and EX_Rd matches (non-load);
  - 1 if MEM_MemRead, MEM_RegWrite and MEM_Rd matches;
  - otherwise 0.
- Forwarding is combinational and recomputed every cycle from the current EX/MEM and MEM/WB stage fields.
  - MEM non-load match gives 01.
  - Otherwise, if the WB-bound value matches, the result is 10. The previous cycle's MEM_Rd, MEM_RegWrite and load are registered internally for this.
  - Otherwise 00.
- State machine:
  - IDLE, isBranch, need = 0: resolve in the same cycle. PCSrc = FlushIFID = TakenIn. Counters update. Stay in IDLE.
  - IDLE, isBranch, need = N > 0: Stall = 1 this cycle, StallCnt <= N-1. Next state is RESOLVE if N = 1, else STALL.
  - STALL: Stall = 1, StallCnt decrements. Go to RESOLVE when StallCnt = 1.
  - RESOLVE: Stall = 0. PCSrc = FlushIFID = TakenIn. Counters update. Go to IDLE.
  - Total stall cycles equal N exactly.
  - Hazard inputs are ignored while in STALL, because upstream stages advance deterministically.
- Output rules:
  - Stall and FlushIFID are never both 1.
  - PCSrc and FlushIFID are 1 for exactly one cycle per taken branch.
  - Non-branch instructions produce all-zero control outputs.
- Counters: BranchCount increments on each resolve; TakenCount increments on each taken resolve. Both saturate at all-ones.

Decomposition:
- Shared package holds:
  - opcode constants (OP_REGIMM, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ);
  - forwarding encodings (FWD_RF, FWD_EXMEM, FWD_MEMWB);
  - the state enum (IDLE, STALL, RESOLVE).
- Sub-module branch_hazard_detect: the combinational need and forwarding computation, instantiated once per operand.

Test Plan:
- beq $4,$5 with no in-flight writers, TakenIn = 1 -> Stall stays 0; PCSrc and FlushIFID are 1 in the same cycle; ForwardA = ForwardB = 00; BranchCount = 1, TakenCount = 1.
- EX is lw $4 and ID is beq $4,$5 -> Stall = 1 for exactly 2 cycles, then RESOLVE with ForwardA = 10; TakenIn = 0 gives PCSrc = 0 and TakenCount unchanged.
- EX is add $4 and ID is bne $4,$0 -> Stall = 1 for 1 cycle, then ForwardA = 01; TakenIn = 1 gives a PCSrc pulse of one cycle.
- EX writes $0 and ID is beq $0,$0 -> no stall; forward selects are 00.
- bgtz $3 with EX writing $3's partner register $7 in Rt position -> no stall, since Rt is ignored for single-operand branches.
- Reset asserted in the second STALL cycle of the lw case -> next cycle is IDLE with all outputs 0 and counters 0; preload both counters at 16'hFFFF, take a branch -> both remain at 16'hFFFF.

Source files
------------

// File: rtl/branch_resolve_ctrl_pkg.sv
// Shared definitions for the ID-stage branch resolution controller.
// Holds the branch opcodes, the comparator forwarding selects and the controller states.
package branch_resolve_ctrl_pkg;

    localparam logic [5:0] OP_REGIMM = 6'b000001;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] OP_BLEZ   = 6'b000110;
    localparam logic [5:0] OP_BGTZ   = 6'b000111;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STALL   = 2'd1,
        RESOLVE = 2'd2
    } state_t;

    function automatic logic isBranchOp(input logic [5:0] op);
        return (op == OP_REGIMM) || (op == OP_BEQ) || (op == OP_BNE) ||
               (op == OP_BLEZ) || (op == OP_BGTZ);
    endfunction

    // Only beq/bne compare two registers; the other branches test rs alone.
    function automatic logic usesRt(input logic [5:0] op);
        return (op == OP_BEQ) || (op == OP_BNE);
    endfunction

endpackage

// File: rtl/branch_resolve_ctrl_hazard_detect.sv
// Per-operand stall need and comparator forward select for one branch source register.
// Register 0 is hard-wired, so it never creates a hazard or a forward.
module branch_hazard_detect
    import branch_resolve_ctrl_pkg::*;
(
    input  logic       i_use,
    input  logic [4:0] i_reg,
    input  logic       i_exRegWrite,
    input  logic       i_exMemRead,
    input  logic [4:0] i_exRd,
    input  logic       i_memRegWrite,
    input  logic       i_memMemRead,
    input  logic [4:0] i_memRd,
    input  logic       i_wbRegWrite,
    input  logic [4:0] i_wbRd,
    output logic [1:0] o_need,
    output logic [1:0] o_fwd
);

    logic w_active;
    logic w_exHit;
    logic w_memHit;
    logic w_wbHit;

    assign w_active = i_use && (i_reg != 5'd0);
    assign w_exHit  = w_active && i_exRegWrite && (i_exRd == i_reg);
    assign w_memHit = w_active && i_memRegWrite && (i_memRd == i_reg);
    assign w_wbHit  = w_active && i_wbRegWrite && (i_wbRd == i_reg);

    // An EX load needs its value to reach WB, so it costs one more cycle than an ALU result.
    always_comb begin
        o_need = 2'd0;
        if (w_exHit) begin
            o_need = i_exMemRead ? 2'd2 : 2'd1;
        end else if (w_memHit && i_memMemRead) begin
            o_need = 2'd1;
        end
    end

    always_comb begin
        o_fwd = FWD_RF;
        if (w_memHit && !i_memMemRead) begin
            o_fwd = FWD_EXMEM;
        end else if (w_wbHit) begin
            o_fwd = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Sequences the ID-stage branch comparator: stalls on operand hazards, selects forwarding,
// then drives PCSrc/FlushIFID from the comparator result and keeps saturating statistics.
module branch_resolve_ctrl
    import branch_resolve_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             BranchValid,
    input  logic [5:0]       Opcode,
    input  logic [4:0]       Rs,
    input  logic [4:0]       Rt,
    input  logic             EX_RegWrite,
    input  logic             EX_MemRead,
    input  logic [4:0]       EX_Rd,
    input  logic             MEM_RegWrite,
    input  logic             MEM_MemRead,
    input  logic [4:0]       MEM_Rd,
    input  logic             TakenIn,
    output logic             Stall,
    output logic [1:0]       ForwardA,
    output logic [1:0]       ForwardB,
    output logic             PCSrc,
    output logic             FlushIFID,
    output logic [CNT_W-1:0] BranchCount,
    output logic [CNT_W-1:0] TakenCount
);

    state_t           r_state;
    logic [1:0]       r_stallCnt;
    logic [CNT_W-1:0] r_branchCount;
    logic [CNT_W-1:0] r_takenCount;
    logic             r_wbRegWrite;
    logic [4:0]       r_wbRd;

    logic       w_isBranch;
    logic       w_useRt;
    logic [1:0] w_needA;
    logic [1:0] w_needB;
    logic [1:0] w_need;
    logic [1:0] w_fwdA;
    logic [1:0] w_fwdB;
    logic       w_stall;
    logic       w_resolve;
    logic       w_showFwd;

    assign w_isBranch = BranchValid && isBranchOp(Opcode);
    assign w_useRt    = usesRt(Opcode);

    branch_hazard_detect u_hazardA (
        .i_use         (1'b1),
        .i_reg         (Rs),
        .i_exRegWrite  (EX_RegWrite),
        .i_exMemRead   (EX_MemRead),
        .i_exRd        (EX_Rd),
        .i_memRegWrite (MEM_RegWrite),
        .i_memMemRead  (MEM_MemRead),
        .i_memRd       (MEM_Rd),
        .i_wbRegWrite  (r_wbRegWrite),
        .i_wbRd        (r_wbRd),
        .o_need        (w_needA),
        .o_fwd         (w_fwdA)
    );

    branch_hazard_detect u_hazardB (
        .i_use         (w_useRt),
        .i_reg         (Rt),
        .i_exRegWrite  (EX_RegWrite),
        .i_exMemRead   (EX_MemRead),
        .i_exRd        (EX_Rd),
        .i_memRegWrite (MEM_RegWrite),
        .i_memMemRead  (MEM_MemRead),
        .i_memRd       (MEM_Rd),
        .i_wbRegWrite  (r_wbRegWrite),
        .i_wbRd        (r_wbRd),
        .o_need        (w_needB),
        .o_fwd         (w_fwdB)
    );

    assign w_need = (w_needA > w_needB) ? w_needA : w_needB;

    // A zero-need branch resolves in IDLE the same cycle it is decoded, so control is combinational.
    always_comb begin
        w_stall   = 1'b0;
        w_resolve = 1'b0;
        w_showFwd = 1'b0;
        if (!Reset) begin
            unique case (r_state)
                IDLE: begin
                    if (w_isBranch) begin
                        w_showFwd = 1'b1;
                        if (w_need == 2'd0) begin
                            w_resolve = 1'b1;
                        end else begin
                            w_stall = 1'b1;
                        end
                    end
                end
                STALL: begin
                    w_showFwd = 1'b1;
                    w_stall   = 1'b1;
                end
                RESOLVE: begin
                    w_showFwd = 1'b1;
                    w_resolve = 1'b1;
                end
                default: begin
                    w_stall = 1'b0;
                end
            endcase
        end
    end

    assign Stall       = w_stall;
    assign ForwardA    = w_showFwd ? w_fwdA : FWD_RF;
    assign ForwardB    = w_showFwd ? w_fwdB : FWD_RF;
    assign PCSrc       = w_resolve && TakenIn;
    assign FlushIFID   = w_resolve && TakenIn;
    assign BranchCount = r_branchCount;
    assign TakenCount  = r_takenCount;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state       <= IDLE;
            r_stallCnt    <= 2'd0;
            r_branchCount <= '0;
            r_takenCount  <= '0;
            r_wbRegWrite  <= 1'b0;
            r_wbRd        <= 5'd0;
        end else begin
            r_wbRegWrite <= MEM_RegWrite;
            r_wbRd       <= MEM_Rd;

            unique case (r_state)
                IDLE: begin
                    if (w_isBranch && (w_need != 2'd0)) begin
                        r_stallCnt <= w_need - 2'd1;
                        r_state    <= (w_need == 2'd1) ? RESOLVE : STALL;
                    end
                end
                STALL: begin
                    r_stallCnt <= r_stallCnt - 2'd1;
                    if (r_stallCnt <= 2'd1) begin
                        r_state <= RESOLVE;
                    end
                end
                RESOLVE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase

            if (w_resolve && (r_branchCount != {CNT_W{1'b1}})) begin
                r_branchCount <= r_branchCount + 1'b1;
            end
            if (w_resolve && TakenIn && (r_takenCount != {CNT_W{1'b1}})) begin
                r_takenCount <= r_takenCount + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Self-checking bench for branch_resolve_ctrl: a cycle-level behavioural model checked every
// cycle, plus directed vectors with literal expectations.
module tb_branch_resolve_ctrl;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        BranchValid;
    logic [5:0]  Opcode;
    logic [4:0]  Rs;
    logic [4:0]  Rt;
    logic        EX_RegWrite;
    logic        EX_MemRead;
    logic [4:0]  EX_Rd;
    logic        MEM_RegWrite;
    logic        MEM_MemRead;
    logic [4:0]  MEM_Rd;
    logic        TakenIn;
    logic        Stall;
    logic [1:0]  ForwardA;
    logic [1:0]  ForwardB;
    logic        PCSrc;
    logic        FlushIFID;
    logic [15:0] BranchCount;
    logic [15:0] TakenCount;

    int errors = 0;
    int checks = 0;
    bit armed  = 1'b0;

    // model state: remaining stall cycles, a pending resolve, counters and the WB-bound writer
    int mStallLeft = 0;
    bit mResolvePending = 1'b0;
    int mBranch = 0;
    int mTaken = 0;
    bit mWbRw = 1'b0;
    int mWbRd = 0;

    int eStall, eFa, eFb, ePc, n;
    bit isBr, useRt, active, resolve;

    branch_resolve_ctrl #(.CNT_W(16)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .BranchValid  (BranchValid),
        .Opcode       (Opcode),
        .Rs           (Rs),
        .Rt           (Rt),
        .EX_RegWrite  (EX_RegWrite),
        .EX_MemRead   (EX_MemRead),
        .EX_Rd        (EX_Rd),
        .MEM_RegWrite (MEM_RegWrite),
        .MEM_MemRead  (MEM_MemRead),
        .MEM_Rd       (MEM_Rd),
        .TakenIn      (TakenIn),
        .Stall        (Stall),
        .ForwardA     (ForwardA),
        .ForwardB     (ForwardB),
        .PCSrc        (PCSrc),
        .FlushIFID    (FlushIFID),
        .BranchCount  (BranchCount),
        .TakenCount   (TakenCount)
    );

    always #5 Clk = ~Clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
        end
    endtask

    task automatic applyStimulus(input bit rst, input bit valid, input logic [5:0] op,
                                 input int rs, input int rt,
                                 input bit exRw, input bit exMr, input int exRd,
                                 input bit memRw, input bit memMr, input int memRd,
                                 input bit taken);
        @(posedge Clk);
        #1;
        Reset        = rst;
        BranchValid  = valid;
        Opcode       = op;
        Rs           = 5'(rs);
        Rt           = 5'(rt);
        EX_RegWrite  = exRw;
        EX_MemRead   = exMr;
        EX_Rd        = 5'(exRd);
        MEM_RegWrite = memRw;
        MEM_MemRead  = memMr;
        MEM_Rd       = 5'(memRd);
        TakenIn      = taken;
    endtask

    task automatic nop();
        applyStimulus(0, 0, 6'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    function automatic int needFor(input int r);
        int k;
        k = 0;
        if (r == 0) return 0;
        if (EX_RegWrite && (int'(EX_Rd) == r)) k = EX_MemRead ? 2 : 1;
        if (MEM_RegWrite && MEM_MemRead && (int'(MEM_Rd) == r) && (k < 1)) k = 1;
        return k;
    endfunction

    function automatic int fwdFor(input int r);
        if (r == 0) return 0;
        if (MEM_RegWrite && !MEM_MemRead && (int'(MEM_Rd) == r)) return 1;
        if (mWbRw && (mWbRd == r)) return 2;
        return 0;
    endfunction

    // Inputs are stable from #1 after a rising edge until the next one, so the negedge sees a full cycle.
    always @(negedge Clk) begin
        if (armed) begin
            eStall = 0; eFa = 0; eFb = 0; ePc = 0; resolve = 1'b0;
            isBr  = BranchValid && (Opcode inside {6'd1, 6'd4, 6'd5, 6'd6, 6'd7});
            useRt = (Opcode == 6'd4) || (Opcode == 6'd5);
            if (Reset) begin
                mStallLeft = 0;
                mResolvePending = 1'b0;
            end else begin
                active = (mStallLeft > 0) || mResolvePending || isBr;
                if (active) begin
                    eFa = fwdFor(int'(Rs));
                    eFb = useRt ? fwdFor(int'(Rt)) : 0;
                end
                if (mStallLeft > 0) begin
                    eStall = 1;
                    mStallLeft--;
                    if (mStallLeft == 0) mResolvePending = 1'b1;
                end else if (mResolvePending) begin
                    resolve = 1'b1;
                    mResolvePending = 1'b0;
                end else if (isBr) begin
                    n = needFor(int'(Rs));
                    if (useRt && (needFor(int'(Rt)) > n)) n = needFor(int'(Rt));
                    if (n == 0) begin
                        resolve = 1'b1;
                    end else begin
                        eStall = 1;
                        mStallLeft = n - 1;
                        if (mStallLeft == 0) mResolvePending = 1'b1;
                    end
                end
                ePc = (resolve && TakenIn) ? 1 : 0;
            end
            checkOutput("model.Stall", int'(Stall), eStall);
            checkOutput("model.ForwardA", int'(ForwardA), eFa);
            checkOutput("model.ForwardB", int'(ForwardB), eFb);
            checkOutput("model.PCSrc", int'(PCSrc), ePc);
            checkOutput("model.FlushIFID", int'(FlushIFID), ePc);
            checkOutput("model.BranchCount", int'(BranchCount), mBranch);
            checkOutput("model.TakenCount", int'(TakenCount), mTaken);
            if (Reset) begin
                mBranch = 0;
                mTaken  = 0;
                mWbRw   = 1'b0;
                mWbRd   = 0;
            end else begin
                if (resolve && mBranch < 65535) mBranch++;
                if (resolve && TakenIn && mTaken < 65535) mTaken++;
                mWbRw = MEM_RegWrite;
                mWbRd = int'(MEM_Rd);
            end
        end
    end

    initial begin
        Reset = 1'b1; BranchValid = 1'b0; Opcode = 6'd0; Rs = 5'd0; Rt = 5'd0;
        EX_RegWrite = 1'b0; EX_MemRead = 1'b0; EX_Rd = 5'd0;
        MEM_RegWrite = 1'b0; MEM_MemRead = 1'b0; MEM_Rd = 5'd0; TakenIn = 1'b0;
        @(posedge Clk);
        #1 armed = 1'b1;
        applyStimulus(1, 0, 6'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        nop();
        @(negedge Clk);
        checkOutput("reset.Stall", int'(Stall), 0);
        checkOutput("reset.BranchCount", int'(BranchCount), 0);
        checkOutput("reset.TakenCount", int'(TakenCount), 0);

        // beq $4,$5 with no writers in flight, taken
        applyStimulus(0, 1, 6'b000100, 4, 5, 0, 0, 0, 0, 0, 0, 1);
        @(negedge Clk);
        checkOutput("beq.Stall", int'(Stall), 0);
        checkOutput("beq.PCSrc", int'(PCSrc), 1);
        checkOutput("beq.FlushIFID", int'(FlushIFID), 1);
        checkOutput("beq.ForwardA", int'(ForwardA), 0);
        checkOutput("beq.ForwardB", int'(ForwardB), 0);
        nop();
        @(negedge Clk);
        checkOutput("beq.BranchCount", int'(BranchCount), 1);
        checkOutput("beq.TakenCount", int'(TakenCount), 1);

        // lw $4 in EX, beq $4,$5: two stall cycles then forward from MEM/WB, not taken
        applyStimulus(0, 1, 6'b000100, 4, 5, 1, 1, 4, 0, 0, 0, 0);
        @(negedge Clk);
        checkOutput("lw.stall1", int'(Stall), 1);
        applyStimulus(0, 1, 6'b000100, 4, 5, 0, 0, 0, 1, 1, 4, 0);
        @(negedge Clk);
        checkOutput("lw.stall2", int'(Stall), 1);
        checkOutput("lw.stall2.PCSrc", int'(PCSrc), 0);
        applyStimulus(0, 1, 6'b000100, 4, 5, 0, 0, 0, 0, 0, 0, 0);
        @(negedge Clk);
        checkOutput("lw.resolve.Stall", int'(Stall), 0);
        checkOutput("lw.resolve.ForwardA", int'(ForwardA), 2);
        checkOutput("lw.resolve.PCSrc", int'(PCSrc), 0);
        nop();
        @(negedge Clk);
        checkOutput("lw.BranchCount", int'(BranchCount), 2);
        checkOutput("lw.TakenCount", int'(TakenCount), 1);

        // add $4 in EX, bne $4,$0: one stall cycle then forward from EX/MEM, taken
        applyStimulus(0, 1, 6'b000101, 4, 0, 1, 0, 4, 0, 0, 0, 1);
        @(negedge Clk);
        checkOutput("add.stall", int'(Stall), 1);
        checkOutput("add.stall.PCSrc", int'(PCSrc), 0);
        applyStimulus(0, 1, 6'b000101, 4, 0, 0, 0, 0, 1, 0, 4, 1);
        @(negedge Clk);
        checkOutput("add.resolve.Stall", int'(Stall), 0);
        checkOutput("add.resolve.ForwardA", int'(ForwardA), 1);
        checkOutput("add.resolve.ForwardB", int'(ForwardB), 0);
        checkOutput("add.resolve.PCSrc", int'(PCSrc), 1);
        nop();
        @(negedge Clk);
        checkOutput("add.after.PCSrc", int'(PCSrc), 0);
        checkOutput("add.BranchCount", int'(BranchCount), 3);
        checkOutput("add.TakenCount", int'(TakenCount), 2);

        // EX load writing $0, beq $0,$0: register 0 never hazards
        applyStimulus(0, 1, 6'b000100, 0, 0, 1, 1, 0, 1, 0, 0, 0);
        @(negedge Clk);
        checkOutput("r0.Stall", int'(Stall), 0);
        checkOutput("r0.ForwardA", int'(ForwardA), 0);
        checkOutput("r0.ForwardB", int'(ForwardB), 0);

        // bgtz $3 with Rt=$7 and an EX load to $7: Rt ignored
        applyStimulus(0, 1, 6'b000111, 3, 7, 1, 1, 7, 0, 0, 0, 0);
        @(negedge Clk);
        checkOutput("bgtz.Stall", int'(Stall), 0);
        nop();
        @(negedge Clk);
        checkOutput("bgtz.BranchCount", int'(BranchCount), 5);

        // Reset during the second stall cycle of the lw case
        applyStimulus(0, 1, 6'b000100, 4, 5, 1, 1, 4, 0, 0, 0, 1);
        @(negedge Clk);
        checkOutput("rst.stall1", int'(Stall), 1);
        applyStimulus(1, 1, 6'b000100, 4, 5, 0, 0, 0, 1, 1, 4, 1);
        @(negedge Clk);
        checkOutput("rst.during.Stall", int'(Stall), 0);
        checkOutput("rst.during.PCSrc", int'(PCSrc), 0);
        nop();
        @(negedge Clk);
        checkOutput("rst.after.Stall", int'(Stall), 0);
        checkOutput("rst.after.PCSrc", int'(PCSrc), 0);
        checkOutput("rst.after.FlushIFID", int'(FlushIFID), 0);
        checkOutput("rst.after.BranchCount", int'(BranchCount), 0);
        checkOutput("rst.after.TakenCount", int'(TakenCount), 0);

        // Drive both counters to all-ones, then one more taken branch must not wrap
        for (int i = 0; i < 65535; i++) begin
            applyStimulus(0, 1, 6'b000100, 1, 2, 0, 0, 0, 0, 0, 0, 1);
        end
        nop();
        @(negedge Clk);
        checkOutput("sat.fill.BranchCount", int'(BranchCount), 65535);
        checkOutput("sat.fill.TakenCount", int'(TakenCount), 65535);
        applyStimulus(0, 1, 6'b000100, 1, 2, 0, 0, 0, 0, 0, 0, 1);
        @(negedge Clk);
        checkOutput("sat.extra.PCSrc", int'(PCSrc), 1);
        nop();
        @(negedge Clk);
        checkOutput("sat.hold.BranchCount", int'(BranchCount), 65535);
        checkOutput("sat.hold.TakenCount", int'(TakenCount), 65535);

        nop();
        @(negedge Clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
